// File: rtl/mem_responder_if.sv
// CPU memory bus between initiator and mem_responder: rd/wr/ack 4-phase handshake plus preload side-band.
// No latency or backpressure of its own; the responder paces the bus through ack.
interface mem_responder_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rd;
  logic          wr;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          err;
  logic          busy;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  modport master (
    output addr, wdata, rd, wr, ld_en, ld_addr, ld_data,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  addr, wdata, rd, wr, ld_en, ld_addr, ld_data,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// 2**AW x DW RAM target: ack rises WAIT+1 edges after accept, then stays high until rd|wr drop.
// Backpressure: one outstanding request; busy is high and new strobes/preloads are ignored until IDLE.
module mem_responder #(
  parameter int AW   = 5,
  parameter int DW   = 8,
  parameter int WAIT = 1
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic       HAS_WAIT = (WAIT > 0);
  localparam logic [3:0] WAIT_LD  = 4'((WAIT > 0) ? WAIT - 1 : 0);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] wdata_l;
  logic          op_wr;
  logic          conflict;
  logic          ack_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;
  logic          req;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  assign req = bus.rd | bus.wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      addr_l   <= '0;
      wdata_l  <= '0;
      op_wr    <= 1'b0;
      conflict <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_l   <= bus.addr;
            wdata_l  <= bus.wdata;
            op_wr    <= bus.wr;
            conflict <= bus.rd & bus.wr;
            if (HAS_WAIT) begin
              state <= S_WAIT;
              cnt   <= WAIT_LD;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // A rd&wr conflict answers with err and leaves both RAM and rdata untouched
          ack_q <= 1'b1;
          err_q <= conflict;
          if (!conflict && !op_wr) begin
            rdata_q <= mem[addr_l];
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (!req) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Preload only lands in IDLE and bus writes only in RESP, so one write port serves both
  always_comb begin
    mem_we = 1'b0;
    mem_wa = bus.ld_addr;
    mem_wd = bus.ld_data;
    if (!rst) begin
      if (state == S_IDLE && bus.ld_en) begin
        mem_we = 1'b1;
      end else if (state == S_RESP && op_wr && !conflict) begin
        mem_we = 1'b1;
        mem_wa = addr_l;
        mem_wd = wdata_l;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: WAIT=1 and WAIT=0 instances, directed transactions,
// expected responses queued at issue and checked by per-instance monitors on each ack rise.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  mem_responder_if #(.AW(5), .DW(8)) b1 ();
  mem_responder_if #(.AW(5), .DW(8)) b0 ();

  mem_responder #(.AW(5), .DW(8), .WAIT(1)) u_w1 (.clk(clk), .rst(rst), .bus(b1));
  mem_responder #(.AW(5), .DW(8), .WAIT(0)) u_w0 (.clk(clk), .rst(rst), .bus(b0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive(input int u, input logic r, input logic w,
                       input logic [4:0] a, input logic [7:0] d);
    if (u == 1) begin b1.rd = r; b1.wr = w; b1.addr = a; b1.wdata = d; end
    else        begin b0.rd = r; b0.wr = w; b0.addr = a; b0.wdata = d; end
  endtask

  task automatic set_ld(input int u, input logic en, input logic [4:0] a, input logic [7:0] d);
    if (u == 1) begin b1.ld_en = en; b1.ld_addr = a; b1.ld_data = d; end
    else        begin b0.ld_en = en; b0.ld_addr = a; b0.ld_data = d; end
  endtask

  function automatic logic get_ack(input int u);
    return (u == 1) ? b1.ack : b0.ack;
  endfunction

  function automatic logic get_busy(input int u);
    return (u == 1) ? b1.busy : b0.busy;
  endfunction

  // Called and returns on a negedge
  task automatic preload(input int u, input logic [4:0] a, input logic [7:0] d);
    set_ld(u, 1'b1, a, d);
    @(negedge clk);
    set_ld(u, 1'b0, 5'd0, 8'd0);
  endtask

  // ldm: 0 none, 1 preload coincident with the request, 2 preload held while busy
  task automatic transact(input int u, input logic r, input logic w,
                          input logic [4:0] a, input logic [7:0] d,
                          input logic [7:0] er, input logic ee, input int hold,
                          input int ldm, input logic [4:0] la, input logic [7:0] lv);
    exp_t e;
    logic got;
    int   w_cyc;
    w_cyc   = (u == 1) ? 1 : 0;
    e.rdata = er;
    e.err   = ee;
    e.cyc   = cyc + w_cyc + 2;
    if (u == 1) q1.push_back(e); else q0.push_back(e);
    drive(u, r, w, a, d);
    if (ldm == 1) set_ld(u, 1'b1, la, lv);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("busy_after_accept", get_busy(u), 1'b1);
        if (ldm == 1) set_ld(u, 1'b0, 5'd0, 8'd0);
        if (ldm == 2) set_ld(u, 1'b1, la, lv);
      end
      got = get_ack(u);
    end
    if (!got) chk("ack_timeout", 1'b0, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("ack_held", get_ack(u), 1'b1);
    end
    drive(u, 1'b0, 1'b0, 5'd0, 8'd0);
    set_ld(u, 1'b0, 5'd0, 8'd0);
    @(negedge clk);
    chk("ack_drop", get_ack(u), 1'b0);
    chk("busy_gap", get_busy(u), 1'b0);
  endtask

  initial begin : mon1
    logic p;
    exp_t e;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (b1.ack && !p) begin
        if (q1.size() == 0) chk("w1_unexpected_ack", 1'b1, 1'b0);
        else begin
          e = q1.pop_front();
          chk("w1_rdata", b1.rdata, e.rdata);
          chk("w1_err", b1.err, e.err);
          chk("w1_latency_cycle", cyc, e.cyc);
        end
      end
      p = b1.ack;
    end
  end

  initial begin : mon0
    logic p;
    exp_t e;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (b0.ack && !p) begin
        if (q0.size() == 0) chk("w0_unexpected_ack", 1'b1, 1'b0);
        else begin
          e = q0.pop_front();
          chk("w0_rdata", b0.rdata, e.rdata);
          chk("w0_err", b0.err, e.err);
          chk("w0_latency_cycle", cyc, e.cyc);
        end
      end
      p = b0.ack;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    set_ld(1, 1'b0, 5'd0, 8'd0);
    set_ld(0, 1'b0, 5'd0, 8'd0);
    repeat (2) @(negedge clk);
    chk("rst_ack", b1.ack, 1'b0);
    chk("rst_err", b1.err, 1'b0);
    chk("rst_rdata", b1.rdata, 8'h00);
    chk("rst_busy", b1.busy, 1'b0);
    chk("rst_busy_w0", b0.busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    preload(1, 5'd3, 8'hA5);
    preload(1, 5'd4, 8'h11);
    preload(1, 5'd7, 8'h00);
    preload(1, 5'd9, 8'h33);

    transact(1, 1'b1, 1'b0, 5'd3,  8'h00, 8'hA5, 1'b0, 1, 0, 5'd0, 8'h00);
    transact(1, 1'b0, 1'b1, 5'd31, 8'h5C, 8'hA5, 1'b0, 0, 0, 5'd0, 8'h00);
    transact(1, 1'b1, 1'b0, 5'd31, 8'h00, 8'h5C, 1'b0, 0, 0, 5'd0, 8'h00);
    transact(1, 1'b1, 1'b1, 5'd4,  8'hEE, 8'h5C, 1'b1, 2, 0, 5'd0, 8'h00);
    transact(1, 1'b1, 1'b0, 5'd4,  8'h00, 8'h11, 1'b0, 0, 0, 5'd0, 8'h00);

    // Reset lands while the write to addr 7 is still waiting
    drive(1, 1'b0, 1'b1, 5'd7, 8'hFF);
    @(negedge clk);
    chk("busy_in_wait", b1.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", b1.ack, 1'b0);
    chk("rst_mid_busy", b1.busy, 1'b0);
    drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    transact(1, 1'b1, 1'b0, 5'd7,  8'h00, 8'h00, 1'b0, 0, 0, 5'd0, 8'h00);
    transact(1, 1'b1, 1'b0, 5'd31, 8'h00, 8'h5C, 1'b0, 0, 0, 5'd0, 8'h00);

    transact(1, 1'b1, 1'b0, 5'd3,  8'h00, 8'hA5, 1'b0, 1, 2, 5'd9, 8'h22);
    transact(1, 1'b1, 1'b0, 5'd9,  8'h00, 8'h33, 1'b0, 0, 0, 5'd0, 8'h00);
    transact(1, 1'b1, 1'b0, 5'd9,  8'h00, 8'h22, 1'b0, 0, 1, 5'd9, 8'h22);
    transact(1, 1'b0, 1'b1, 5'd9,  8'h44, 8'h22, 1'b0, 0, 1, 5'd9, 8'h99);
    transact(1, 1'b1, 1'b0, 5'd9,  8'h00, 8'h44, 1'b0, 0, 0, 5'd0, 8'h00);

    preload(0, 5'd2, 8'h77);
    preload(0, 5'd5, 8'h88);
    transact(0, 1'b1, 1'b0, 5'd2, 8'h00, 8'h77, 1'b0, 0, 0, 5'd0, 8'h00);
    transact(0, 1'b1, 1'b0, 5'd5, 8'h00, 8'h88, 1'b0, 0, 0, 5'd0, 8'h00);
    transact(0, 1'b0, 1'b1, 5'd5, 8'hAB, 8'h88, 1'b0, 0, 0, 5'd0, 8'h00);
    transact(0, 1'b1, 1'b0, 5'd5, 8'h00, 8'hAB, 1'b0, 1, 0, 5'd0, 8'h00);

    repeat (3) @(negedge clk);
    chk("w1_queue_drained", q1.size(), 0);
    chk("w0_queue_drained", q0.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
